muldiv_seq: RTL and testbench

- Iterative multi-cycle RV32M multiply/divide sequencer next to the single-cycle ALU in the execute stage.
- Decode steers M-extension ops here instead of the ALU. The core stalls while `ready` is low and writes back `result` on `done`.
- The datapath is one XLEN-bit add/subtract, shift-add for multiply and restoring division for divide, stepped by an internal FSM and counter.

---
 rtl/muldiv_seq.sv | 162 ++++++++++++++++
 tb/tb_muldiv_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer: shift-add multiply, restoring divide, one add/sub per cycle.
// Optional MULDIV_EARLY_OUT_EN skips the iteration phase for divide-by-zero and zero multiply operands.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      muldiv_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [2:0]          r_op;
  logic [2*XLEN-1:0]   r_acc;
  logic [XLEN-1:0]     r_mcand;
  logic [XLEN-1:0]     r_opA;
  logic [XLEN-1:0]     r_result;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_divZero;
  logic                r_negRes;

  logic                w_accept;
  logic                w_signA;
  logic                w_signB;
  logic [XLEN-1:0]     w_absA;
  logic [XLEN-1:0]     w_absB;
  logic                w_negRes;
  logic                w_early;
  logic [XLEN:0]       w_addA;
  logic [XLEN+1:0]     w_addRes;
  logic [2*XLEN-1:0]   w_accNext;
  logic [2*XLEN-1:0]   w_prod;
  logic [XLEN-1:0]     w_quot;
  logic [XLEN-1:0]     w_rem;
  logic [XLEN-1:0]     w_finResult;

  assign w_accept = (r_state == IDLE) && start && !kill;

  // MULHSU: only rs1 is signed; MUL is treated as unsigned since its low half is sign-agnostic.
  always_comb begin
    w_signA = 1'b0;
    w_signB = 1'b0;
    case (muldiv_op)
      3'b001, 3'b100, 3'b110: begin
        w_signA = op_a[XLEN-1];
        w_signB = op_b[XLEN-1];
      end
      3'b010:  w_signA = op_a[XLEN-1];
      default: ;
    endcase
  end

  assign w_absA   = w_signA ? -op_a : op_a;
  assign w_absB   = w_signB ? -op_b : op_b;
  assign w_negRes = (muldiv_op == 3'b110) ? w_signA : (w_signA ^ w_signB);

`ifdef MULDIV_EARLY_OUT_EN
  assign w_early = muldiv_op[2] ? (op_b == '0) : ((op_a == '0) || (op_b == '0));
`else
  assign w_early = 1'b0;
`endif

  // Shared adder: multiply adds to the product high half, divide trial-subtracts from the shifted remainder.
  assign w_addA   = r_op[2] ? r_acc[2*XLEN-1:XLEN-1] : {1'b0, r_acc[2*XLEN-1:XLEN]};
  assign w_addRes = r_op[2] ? ({1'b0, w_addA} - {2'b0, r_mcand})
                            : ({1'b0, w_addA} + {2'b0, r_mcand});

  always_comb begin
    w_accNext = r_acc;
    if (r_op[2]) begin
      if (!w_addRes[XLEN+1]) w_accNext = {w_addRes[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      else                   w_accNext = {r_acc[2*XLEN-2:0], 1'b0};
    end else begin
      if (r_acc[0]) w_accNext = {w_addRes[XLEN:0], r_acc[XLEN-1:1]};
      else          w_accNext = {1'b0, r_acc[2*XLEN-1:1]};
    end
  end

  assign w_prod = r_negRes ? -r_acc : r_acc;
  assign w_quot = r_acc[XLEN-1:0];
  assign w_rem  = r_acc[2*XLEN-1:XLEN];

  // Divide-by-zero results override the sign correction.
  always_comb begin
    w_finResult = '0;
    if (r_op[2]) begin
      if (r_op[1]) w_finResult = r_divZero ? r_opA : (r_negRes ? -w_rem : w_rem);
      else         w_finResult = r_divZero ? '1 : (r_negRes ? -w_quot : w_quot);
    end else begin
      w_finResult = (r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    w_next = r_state;
    ready  = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: begin
        ready = 1'b1;
        if (w_accept) w_next = w_early ? FIN : CALC;
      end
      CALC:    if (r_cnt == LAST_CNT) w_next = FIN;
      FIN:     w_next = DONE;
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
    if (kill || rst) begin
      w_next = IDLE;
      done   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= '0;
      r_acc     <= '0;
      r_mcand   <= '0;
      r_opA     <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
      r_divZero <= 1'b0;
      r_negRes  <= 1'b0;
    end else if (w_accept) begin
      r_op      <= muldiv_op;
      r_acc     <= w_early ? '0 : {{XLEN{1'b0}}, w_absA};
      r_mcand   <= w_absB;
      r_opA     <= op_a;
      r_cnt     <= '0;
      r_divZero <= (op_b == '0);
      r_negRes  <= w_negRes;
    end else if (r_state == CALC && !kill) begin
      r_acc <= w_accNext;
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (r_state == FIN && !kill) begin
      r_result <= w_finResult;
    end
  end

  assign result = r_result;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq (XLEN=32): results, latency, divide-by-zero, kill and reset.
module tb_muldiv_seq;

  localparam int XLEN = 32;
`ifdef MULDIV_EARLY_OUT_EN
  localparam int EXP_SHORT = 2;
`else
  localparam int EXP_SHORT = 34;
`endif

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            kill = 1'b0;
  logic [2:0]      muldiv_op = 3'b000;
  logic [XLEN-1:0] op_a = '0;
  logic [XLEN-1:0] op_b = '0;
  logic            ready;
  logic            done;
  logic [XLEN-1:0] result;

  int passCnt = 0;
  int totalCnt = 0;

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .start(start), .kill(kill), .muldiv_op(muldiv_op),
    .op_a(op_a), .op_b(op_b), .ready(ready), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Drives one request and measures cycles from the accept edge to the edge that samples done (-1 on timeout).
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    muldiv_op = op; op_a = a; op_b = b; start = 1'b1;
    @(posedge clk);
    lat = -1;
    res = 'x;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (done === 1'b1) begin
        lat = i;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; kill = 1'b0;
    repeat (3) @(negedge clk);
    totalCnt++;
    if (ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", ready); else passCnt++;
    totalCnt++;
    if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passCnt++;
    totalCnt++;
    if (result !== 32'h0) $display("[TB] FAIL reset_result: got %h expected 00000000", result); else passCnt++;
    rst = 1'b0;
  endtask

  task automatic run_table(input string name, input vec_t vecs[$], input int expLat);
    logic [31:0] res;
    int lat;
    foreach (vecs[i]) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
      totalCnt++;
      if (res !== vecs[i].exp)
        $display("[TB] FAIL %s[%0d]_result: got %h expected %h", name, i, res, vecs[i].exp);
      else passCnt++;
      totalCnt++;
      if (lat != expLat)
        $display("[TB] FAIL %s[%0d]_latency: got %0d expected %0d", name, i, lat, expLat);
      else passCnt++;
    end
  endtask

  task automatic test_multiply();
    vec_t v[$];
    v.push_back(vec_t'{MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE});
    v.push_back(vec_t'{MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000});
    v.push_back(vec_t'{MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001});
    v.push_back(vec_t'{MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF});
    v.push_back(vec_t'{MUL,    32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB});
    v.push_back(vec_t'{MULH,   32'h80000000, 32'h80000000, 32'h40000000});
    v.push_back(vec_t'{MULH,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF});
    v.push_back(vec_t'{MULHU,  32'h12345678, 32'h00000010, 32'h00000001});
    run_table("mul", v, 34);
  endtask

  task automatic test_divide();
    vec_t v[$];
    v.push_back(vec_t'{DIV,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD});
    v.push_back(vec_t'{REM,  32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF});
    v.push_back(vec_t'{DIVU, 32'd100,      32'd7,        32'd14});
    v.push_back(vec_t'{REMU, 32'd100,      32'd7,        32'd2});
    v.push_back(vec_t'{DIV,  32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD});
    v.push_back(vec_t'{REM,  32'h00000007, 32'hFFFFFFFE, 32'h00000001});
    v.push_back(vec_t'{DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000});
    v.push_back(vec_t'{REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000});
    run_table("div", v, 34);
  endtask

  task automatic test_zero_operands();
    vec_t v[$];
    v.push_back(vec_t'{DIVU,  32'd5,        32'd0, 32'hFFFFFFFF});
    v.push_back(vec_t'{REMU,  32'd5,        32'd0, 32'd5});
    v.push_back(vec_t'{DIV,   32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF});
    v.push_back(vec_t'{REM,   32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB});
    v.push_back(vec_t'{MUL,   32'h00001234, 32'd0, 32'h00000000});
    v.push_back(vec_t'{MULHU, 32'd0,        32'd5, 32'h00000000});
    run_table("zero", v, EXP_SHORT);
  endtask

  task automatic test_abort();
    logic [31:0] res;
    int lat;
    int doneSeen = 0;
    do_op(DIVU, 32'd100, 32'd7, res, lat);
    totalCnt++;
    if (res !== 32'd14) $display("[TB] FAIL abort_setup: got %h expected 0000000e", res); else passCnt++;

    @(negedge clk);
    muldiv_op = DIVU; op_a = 32'd50; op_b = 32'd5; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
      start = (k == 5);
      if (k == 5) begin
        muldiv_op = MUL; op_a = 32'd3; op_b = 32'd3;
      end
      kill = (k == 10);
    end
    @(negedge clk);
    kill = 1'b0;
    totalCnt++;
    if (ready !== 1'b1) $display("[TB] FAIL abort_ready: got %b expected 1", ready); else passCnt++;
    totalCnt++;
    if (result !== 32'd14) $display("[TB] FAIL abort_result: got %h expected 0000000e", result); else passCnt++;

    // A start in the same cycle as kill must not be accepted.
    muldiv_op = DIVU; op_a = 32'd9; op_b = 32'd3; start = 1'b1; kill = 1'b1;
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    totalCnt++;
    if (ready !== 1'b1) $display("[TB] FAIL kill_blocks_start: ready got %b expected 1", ready); else passCnt++;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done === 1'b1) doneSeen++;
    end
    totalCnt++;
    if (doneSeen != 0) $display("[TB] FAIL abort_no_done: got %0d pulses expected 0", doneSeen); else passCnt++;
    totalCnt++;
    if (result !== 32'd14) $display("[TB] FAIL abort_result_hold: got %h expected 0000000e", result); else passCnt++;
  endtask

  task automatic test_reset_midop();
    @(negedge clk);
    muldiv_op = DIVU; op_a = 32'd50; op_b = 32'd5; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      rst = (k == 20);
    end
    @(negedge clk);
    rst = 1'b0;
    totalCnt++;
    if (ready !== 1'b1) $display("[TB] FAIL midrst_ready: got %b expected 1", ready); else passCnt++;
    totalCnt++;
    if (result !== 32'h0) $display("[TB] FAIL midrst_result: got %h expected 00000000", result); else passCnt++;
    totalCnt++;
    if (done !== 1'b0) $display("[TB] FAIL midrst_done: got %b expected 0", done); else passCnt++;
  endtask

  task automatic test_back_to_back();
    vec_t v[$];
    v.push_back(vec_t'{DIVU, 32'd50, 32'd5, 32'd10});
    v.push_back(vec_t'{MUL,  32'd6,  32'd7, 32'd42});
    v.push_back(vec_t'{REMU, 32'd50, 32'd7, 32'd1});
    run_table("b2b", v, 34);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_zero_operands();
    test_abort();
    test_reset_midop();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
